// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder used by the bit-serial add/sub datapath
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial add/subtract, LSB-first, one bit per clock
module serial_add_sub #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SnA,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  CO,
  output logic                  OVF
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] a_sr;
  logic [DATA_WIDTH-1:0] b_sr;
  logic [DATA_WIDTH-1:0] res_sr;
  logic [CW-1:0]         cnt_q;
  logic                  carry_q;
  logic                  fa_s;
  logic                  fa_co;
  logic                  last_bit;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      RESULT  <= '0;
      CO      <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            // Subtraction is OP1 + ~OP2 + 1: invert B here, the +1 rides in on the carry.
            a_sr    <= OP1;
            b_sr    <= SnA ? ~OP2 : OP2;
            carry_q <= SnA;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          a_sr    <= {1'b0, a_sr[DATA_WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[DATA_WIDTH-1:1]};
          res_sr  <= {fa_s, res_sr[DATA_WIDTH-1:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q still holds the carry into the MSB at this edge.
            RESULT <= {fa_s, res_sr[DATA_WIDTH-1:1]};
            CO     <= fa_co;
            OVF    <= carry_q ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub
module tb_serial_add_sub;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        sna;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        co;
  logic        ovf;

  int checks;
  int errors;

  serial_add_sub #(.DATA_WIDTH(32)) dut (
    .CLK    (clk),
    .RST    (rstn),
    .START  (start),
    .SnA    (sna),
    .OP1    (op1),
    .OP2    (op2),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result),
    .CO     (co),
    .OVF    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] bb;
    logic [32:0] sum;
    logic        v;
    bb  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    v   = (a[31] == bb[31]) && (sum[31] != a[31]);
    return {v, sum[32], sum[31:0]};
  endfunction

  // Returns at the falling edge right after the accept edge, with START dropped.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    sna   = s;
    op1   = a;
    op2   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt, output int unstable);
    logic [31:0] held;
    held     = result;
    edges    = 0;
    busy_cnt = 0;
    unstable = 0;
    if (busy) busy_cnt++;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cnt++;
      if (!done && result !== held) unstable++;
    end
    if (!done) check("done_timeout", 32'(edges), 32'd32);
  endtask

  int          edges;
  int          busy_cnt;
  int          unstable;
  int          pulses;
  int          t;
  int          last_t;
  int          n;
  logic [31:0] cap;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;
  logic [33:0] exp_m;

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    sna    = 1'b0;
    op1    = '0;
    op2    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_co_ovf", {30'd0, co, ovf}, 32'd0);
    rstn = 1'b1;

    launch(1'b0, 32'd5, 32'd3);
    wait_done(edges, busy_cnt, unstable);
    check("add5_3_latency", 32'(edges), 32'd32);
    check("add5_3_result", result, 32'd8);
    check("add5_3_co_ovf", {30'd0, co, ovf}, 32'd0);
    @(negedge clk);
    check("add5_3_done_width", {31'd0, done}, 32'd0);
    check("add5_3_busy_cycles", 32'(busy_cnt), 32'd33);
    check("add5_3_busy_after", {31'd0, busy}, 32'd0);

    launch(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(edges, busy_cnt, unstable);
    check("add_wrap_result", result, 32'd0);
    check("add_wrap_co_ovf", {30'd0, co, ovf}, 32'd2);

    launch(1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_done(edges, busy_cnt, unstable);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_co_ovf", {30'd0, co, ovf}, 32'd1);

    launch(1'b1, 32'd5, 32'd3);
    wait_done(edges, busy_cnt, unstable);
    check("sub5_3_result", result, 32'd2);
    check("sub5_3_co_ovf", {30'd0, co, ovf}, 32'd2);

    launch(1'b1, 32'd3, 32'd5);
    wait_done(edges, busy_cnt, unstable);
    check("sub3_5_result", result, 32'hFFFF_FFFE);
    check("sub3_5_co_ovf", {30'd0, co, ovf}, 32'd0);

    launch(1'b1, 32'h8000_0000, 32'd1);
    wait_done(edges, busy_cnt, unstable);
    check("sub_ovf_result", result, 32'h7FFF_FFFF);
    check("sub_ovf_co_ovf", {30'd0, co, ovf}, 32'd3);

    // START while busy must be dropped without disturbing the operation in flight.
    launch(1'b0, 32'd7, 32'd1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op1   = 32'd9;
    op2   = 32'd9;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    cap    = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        cap = result;
      end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_result", cap, 32'd8);
    launch(1'b0, 32'd10, 32'd20);
    wait_done(edges, busy_cnt, unstable);
    check("hold_stable", 32'(unstable), 32'd0);
    check("hold_next_result", result, 32'd30);

    // Reset partway through a run.
    launch(1'b0, 32'd1, 32'd2);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rstn   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    launch(1'b0, 32'd100, 32'd23);
    wait_done(edges, busy_cnt, unstable);
    check("midrst_relaunch", result, 32'd123);

    // START held high: back-to-back operations, operands swapped at each DONE.
    @(negedge clk);
    ra    = $urandom;
    rb    = $urandom;
    rs    = 1'($urandom_range(0, 1));
    start = 1'b1;
    sna   = rs;
    op1   = ra;
    op2   = rb;
    t      = 0;
    last_t = 0;
    n      = 0;
    while (n < 3 && t < 200) begin
      @(negedge clk);
      t++;
      if (done) begin
        exp_m = model(ra, rb, rs);
        check("held_result", result, exp_m[31:0]);
        check("held_co_ovf", {30'd0, co, ovf}, {30'd0, exp_m[32], exp_m[33]});
        if (n > 0) check("held_spacing", 32'(t - last_t), 32'd34);
        last_t = t;
        n++;
        ra  = $urandom;
        rb  = $urandom;
        rs  = 1'($urandom_range(0, 1));
        sna = rs;
        op1 = ra;
        op2 = rb;
        if (n == 3) start = 1'b0;
      end
    end
    check("held_count", 32'(n), 32'd3);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
